// File: rtl/lowbus_pkg.sv
// Shared types and defaults for the low-FPGA W/R/DATA strobe bus initiator.
// The state successor function encodes both two-pulse bus sequences in one place.
package lowbus_pkg;

    localparam int BUS_W         = 8;
    localparam int DEF_T_PULSE   = 2;
    localparam int DEF_T_GAP     = 2;
    localparam int DEF_T_ACCESS  = 4;
    localparam int DEF_CW        = 8;

    typedef enum logic [3:0] {
        IDLE,
        W1_HI,
        W1_LO,
        W2_HI,
        W2_HOLD,
        R_ACC,
        RW1_HI,
        RW1_LO,
        RW2_HI,
        R_END
    } state_t;

    // The write flag only matters when leaving IDLE; all other states have one successor.
    function automatic state_t succ_state(input state_t s, input logic wr);
        case (s)
            IDLE:    succ_state = wr ? W1_HI : R_ACC;
            W1_HI:   succ_state = W1_LO;
            W1_LO:   succ_state = W2_HI;
            W2_HI:   succ_state = W2_HOLD;
            R_ACC:   succ_state = RW1_HI;
            RW1_HI:  succ_state = RW1_LO;
            RW1_LO:  succ_state = RW2_HI;
            RW2_HI:  succ_state = R_END;
            default: succ_state = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lowbus_phase_timer.sv
// Loadable down-counter timing each bus phase; done is high while the count is zero.
// The counter parks at zero rather than wrapping.
module lowbus_phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lowbus_master.sv
// Bus initiator: turns single-cycle host requests into the two-W-pulse sequences the
// lower-FPGA responder decodes, leaving its W-toggle phase back at its post-reset value.
module lowbus_master
    import lowbus_pkg::*;
#(
    parameter int T_PULSE  = DEF_T_PULSE,
    parameter int T_GAP    = DEF_T_GAP,
    parameter int T_ACCESS = DEF_T_ACCESS,
    parameter int CW       = DEF_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [BUS_W-1:0] req_wdata,
    output logic [BUS_W-1:0] rdata,
    output logic             rdata_valid,
    output logic             busy,
    output logic             bus_w,
    output logic             bus_r,
    inout  wire  [BUS_W-1:0] bus_data
);

    localparam logic [CW-1:0] PULSE_LD  = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(T_GAP - 1);
    localparam logic [CW-1:0] ACCESS_LD = CW'(T_ACCESS - 1);

    state_t          state;
    state_t          succ;
    state_t          nxt;
    logic            advance;
    logic            accept;
    logic            load;
    logic [CW-1:0]   load_value;
    logic            timer_done;
    logic            oe;
    logic [BUS_W-1:0] data_out;

    lowbus_phase_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .done       (timer_done)
    );

    always_comb begin
        accept  = (state == IDLE) && req_valid;
        advance = (state == IDLE) ? req_valid : timer_done;
        succ    = succ_state(state, req_write);
        nxt     = advance ? succ : state;
        load    = advance && (succ != IDLE);
        case (succ)
            W1_HI, W2_HI, RW1_HI, RW2_HI:   load_value = PULSE_LD;
            W1_LO, W2_HOLD, RW1_LO, R_END:  load_value = GAP_LD;
            R_ACC:                          load_value = ACCESS_LD;
            default:                        load_value = '0;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus_w       <= 1'b0;
            bus_r       <= 1'b0;
            oe          <= 1'b0;
            data_out    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
        end else begin
            state       <= nxt;
            bus_w       <= nxt inside {W1_HI, W2_HI, RW1_HI, RW2_HI};
            bus_r       <= nxt inside {R_ACC, RW1_HI, RW1_LO, RW2_HI};
            // Drive only after the first W pulse has released any responder drive.
            oe          <= nxt inside {W1_LO, W2_HI, W2_HOLD};
            busy        <= (nxt != IDLE);
            req_ready   <= (nxt == IDLE);
            rdata_valid <= (state == R_ACC) && timer_done;
            if (accept) begin
                data_out <= req_wdata;
            end
            if ((state == R_ACC) && timer_done) begin
                rdata <= bus_data;
            end
        end
    end

    assign bus_data = oe ? data_out : {BUS_W{1'bz}};

endmodule

// File: tb/tb_lowbus_master.sv
// Directed bench: default-timing master plus a fast-timing master, each with a
// behavioural LED/switch responder that toggles its phase on every W rise.
module tb_lowbus_master;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   contention_a = 0;
    int   contention_b = 0;

    logic       req_valid_a = 1'b0, req_write_a = 1'b0;
    logic [7:0] req_wdata_a = 8'h00;
    logic       req_ready_a, rdata_valid_a, busy_a, bus_w_a, bus_r_a;
    logic [7:0] rdata_a;
    wire  [7:0] bus_data_a;

    logic       req_valid_b = 1'b0, req_write_b = 1'b0;
    logic [7:0] req_wdata_b = 8'h00;
    logic       req_ready_b, rdata_valid_b, busy_b, bus_w_b, bus_r_b;
    logic [7:0] rdata_b;
    wire  [7:0] bus_data_b;

    logic       ph_a, ph_b;
    logic [7:0] leds_a, leds_b;
    logic [7:0] sw_a = 8'h00, sw_b = 8'h00;
    logic       drv_a, drv_b;

    always #5 clk = ~clk;

    lowbus_master dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write_a), .req_wdata(req_wdata_a), .rdata(rdata_a),
        .rdata_valid(rdata_valid_a), .busy(busy_a), .bus_w(bus_w_a), .bus_r(bus_r_a),
        .bus_data(bus_data_a)
    );

    lowbus_master #(.T_PULSE(1), .T_GAP(1), .T_ACCESS(2)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write_b), .req_wdata(req_wdata_b), .rdata(rdata_b),
        .rdata_valid(rdata_valid_b), .busy(busy_b), .bus_w(bus_w_b), .bus_r(bus_r_b),
        .bus_data(bus_data_b)
    );

    // Responder: drives switches while R=1 in phase 0; second W rise latches LEDs unless R=1.
    always @(posedge bus_w_a or negedge reset) begin
        if (!reset) begin
            ph_a <= 1'b0;
            leds_a <= 8'h00;
        end else begin
            if (ph_a && !bus_r_a) leds_a <= bus_data_a;
            ph_a <= ~ph_a;
        end
    end
    assign drv_a = bus_r_a && !ph_a;
    assign bus_data_a = drv_a ? sw_a : 8'hzz;

    always @(posedge bus_w_b or negedge reset) begin
        if (!reset) begin
            ph_b <= 1'b0;
            leds_b <= 8'h00;
        end else begin
            if (ph_b && !bus_r_b) leds_b <= bus_data_b;
            ph_b <= ~ph_b;
        end
    end
    assign drv_b = bus_r_b && !ph_b;
    assign bus_data_b = drv_b ? sw_b : 8'hzz;

    always @(negedge clk) begin
        if (dut_a.oe && drv_a) contention_a <= contention_a + 1;
        if (dut_b.oe && drv_b) contention_b <= contention_b + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (bus_w_a !== 1'b0) begin failures++; $display("FAIL reset_bus_w got=%b want=0", bus_w_a); end
        checks++; if (bus_r_a !== 1'b0) begin failures++; $display("FAIL reset_bus_r got=%b want=0", bus_r_a); end
        checks++; if (dut_a.oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b want=0", dut_a.oe); end
        checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h want=00", rdata_a); end
        checks++; if (rdata_valid_a !== 1'b0) begin failures++; $display("FAIL reset_rdata_valid got=%b want=0", rdata_valid_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        checks++; if (req_ready_a !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready_a); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write;
        logic exp_w, exp_oe;
        req_valid_a = 1'b1; req_write_a = 1'b1; req_wdata_a = 8'hA5;
        tick();
        req_valid_a = 1'b0; req_wdata_a = 8'h00;
        for (int c = 1; c <= 9; c++) begin
            exp_w  = (c == 1 || c == 2 || c == 5 || c == 6);
            exp_oe = (c >= 3 && c <= 8);
            checks++; if (bus_w_a !== exp_w) begin failures++; $display("FAIL write_bus_w cyc=%0d got=%b want=%b", c, bus_w_a, exp_w); end
            checks++; if (bus_r_a !== 1'b0) begin failures++; $display("FAIL write_bus_r cyc=%0d got=%b want=0", c, bus_r_a); end
            checks++; if (dut_a.oe !== exp_oe) begin failures++; $display("FAIL write_oe cyc=%0d got=%b want=%b", c, dut_a.oe, exp_oe); end
            if (exp_oe) begin
                checks++; if (bus_data_a !== 8'hA5) begin failures++; $display("FAIL write_bus_data cyc=%0d got=%h want=a5", c, bus_data_a); end
            end
            checks++; if (req_ready_a !== (c == 9)) begin failures++; $display("FAIL write_req_ready cyc=%0d got=%b want=%b", c, req_ready_a, (c == 9)); end
            if (c == 5) begin
                checks++; if (leds_a !== 8'hA5) begin failures++; $display("FAIL write_leds_at_w2 got=%h want=a5", leds_a); end
            end
            tick();
        end
        checks++; if (ph_a !== 1'b0) begin failures++; $display("FAIL write_phase got=%b want=0", ph_a); end
    endtask

    task automatic test_read;
        int pulses = 0;
        logic exp_w, exp_r;
        sw_a = 8'h3C;
        req_valid_a = 1'b1; req_write_a = 1'b0; req_wdata_a = 8'hFF;
        tick();
        req_valid_a = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            exp_r = (c <= 10);
            exp_w = (c == 5 || c == 6 || c == 9 || c == 10);
            checks++; if (bus_r_a !== exp_r) begin failures++; $display("FAIL read_bus_r cyc=%0d got=%b want=%b", c, bus_r_a, exp_r); end
            checks++; if (bus_w_a !== exp_w) begin failures++; $display("FAIL read_bus_w cyc=%0d got=%b want=%b", c, bus_w_a, exp_w); end
            checks++; if (dut_a.oe !== 1'b0) begin failures++; $display("FAIL read_oe cyc=%0d got=%b want=0", c, dut_a.oe); end
            if (c <= 8) begin
                checks++; if (drv_a !== (c <= 4)) begin failures++; $display("FAIL read_responder_drive cyc=%0d got=%b want=%b", c, drv_a, (c <= 4)); end
            end
            if (rdata_valid_a) pulses++;
            if (c == 5) begin
                checks++; if (rdata_valid_a !== 1'b1) begin failures++; $display("FAIL read_valid_cycle got=%b want=1", rdata_valid_a); end
                checks++; if (rdata_a !== 8'h3C) begin failures++; $display("FAIL read_rdata got=%h want=3c", rdata_a); end
            end
            checks++; if (req_ready_a !== (c == 13)) begin failures++; $display("FAIL read_req_ready cyc=%0d got=%b want=%b", c, req_ready_a, (c == 13)); end
            tick();
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL read_valid_pulses got=%0d want=1", pulses); end
        checks++; if (rdata_a !== 8'h3C) begin failures++; $display("FAIL read_rdata_hold got=%h want=3c", rdata_a); end
        checks++; if (leds_a !== 8'hA5) begin failures++; $display("FAIL read_leds_unchanged got=%h want=a5", leds_a); end
        checks++; if (ph_a !== 1'b0) begin failures++; $display("FAIL read_phase got=%b want=0", ph_a); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        sw_a = 8'h5A;
        req_valid_a = 1'b1; req_write_a = 1'b0;
        tick();
        req_write_a = 1'b1; req_wdata_a = 8'h0F;
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) begin
                checks++; if (rdata_a !== 8'h5A) begin failures++; $display("FAIL b2b_rdata got=%h want=5a", rdata_a); end
            end
            checks++; if (req_ready_a !== (c == 13)) begin failures++; $display("FAIL b2b_req_ready cyc=%0d got=%b want=%b", c, req_ready_a, (c == 13)); end
            if (c == 14) begin
                checks++; if ({bus_w_a, bus_r_a, busy_a} !== 3'b101) begin failures++; $display("FAIL b2b_write_start got=%b want=101", {bus_w_a, bus_r_a, busy_a}); end
                req_valid_a = 1'b0;
            end
            tick();
        end
        while (!req_ready_a && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n != 7) begin failures++; $display("FAIL b2b_write_len got=%0d want=7", n); end
        checks++; if (leds_a !== 8'h0F) begin failures++; $display("FAIL b2b_leds got=%h want=0f", leds_a); end
        checks++; if (contention_a != 0) begin failures++; $display("FAIL b2b_contention got=%0d want=0", contention_a); end
    endtask

    task automatic test_reset_mid;
        req_valid_a = 1'b1; req_write_a = 1'b1; req_wdata_a = 8'hC3;
        tick();
        req_valid_a = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        checks++; if ({bus_w_a, dut_a.oe} !== 2'b11) begin failures++; $display("FAIL rst_mid_in_w2hi got=%b want=11", {bus_w_a, dut_a.oe}); end
        reset = 1'b0;
        #1;
        checks++; if ({bus_w_a, bus_r_a, dut_a.oe} !== 3'b000) begin failures++; $display("FAIL rst_mid_strobes got=%b want=000", {bus_w_a, bus_r_a, dut_a.oe}); end
        checks++; if ({req_ready_a, busy_a} !== 2'b10) begin failures++; $display("FAIL rst_mid_ready_busy got=%b want=10", {req_ready_a, busy_a}); end
        checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL rst_mid_rdata got=%h want=00", rdata_a); end
        checks++; if (ph_a !== 1'b0) begin failures++; $display("FAIL rst_mid_phase got=%b want=0", ph_a); end
        tick();
        checks++; if ({bus_w_a, dut_a.oe, req_ready_a} !== 3'b001) begin failures++; $display("FAIL rst_mid_held got=%b want=001", {bus_w_a, dut_a.oe, req_ready_a}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fast_timing;
        int n;
        logic wr, got_valid;
        logic [7:0] d, got;
        for (int k = 0; k < 2; k++) begin
            sw_b = 8'h99;
            req_valid_b = 1'b1; req_write_b = (k == 0); req_wdata_b = 8'h66;
            tick();
            req_valid_b = 1'b0;
            n = 0;
            while (busy_b && n < 50) begin
                n++;
                tick();
            end
            checks++; if (n != ((k == 0) ? 4 : 6)) begin failures++; $display("FAIL fast_len kind=%0d got=%0d want=%0d", k, n, (k == 0) ? 4 : 6); end
            tick();
        end
        for (int i = 0; i < 100; i++) begin
            wr = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (!wr) sw_b = d;
            req_valid_b = 1'b1; req_write_b = wr; req_wdata_b = d;
            tick();
            req_valid_b = 1'b0; req_wdata_b = ~d;
            n = 0; got_valid = 1'b0; got = 8'h00;
            while (!req_ready_b && n < 50) begin
                if (rdata_valid_b) begin
                    got_valid = 1'b1;
                    got = rdata_b;
                end
                n++;
                tick();
            end
            if (wr) begin
                checks++; if (leds_b !== d || n >= 50) begin failures++; $display("FAIL fast_write txn=%0d leds=%h want=%h cycles=%0d", i, leds_b, d, n); end
            end else begin
                checks++; if (!got_valid || got !== d || n >= 50) begin failures++; $display("FAIL fast_read txn=%0d got=%h valid=%b want=%h cycles=%0d", i, got, got_valid, d, n); end
            end
        end
        checks++; if (ph_b !== 1'b0) begin failures++; $display("FAIL fast_phase got=%b want=0", ph_b); end
        checks++; if (contention_b != 0) begin failures++; $display("FAIL fast_contention got=%0d want=0", contention_b); end
    endtask

    initial begin
        test_reset();
        test_write();
        tick();
        test_read();
        tick();
        test_back_to_back();
        tick();
        test_reset_mid();
        test_fast_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

endmodule
